// File: rtl/rotary_quad_gen.sv
// Quadrature A/B generator: emits step_count detents of a Gray-coded A/B pattern in the requested direction.
// Latency: zero; rotary_a/b take the PH1 value on the accept edge; one detent lasts 4*PHASE_CYCLES clocks.
// Backpressure: step_ready is high only in IDLE; abort cancels a running request on the next edge without a done pulse.
module rotary_quad_gen #(
    parameter int PHASE_CYCLES = 4,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_valid,
    output logic             step_ready,
    input  logic             step_dir,
    input  logic [CNT_W-1:0] step_count,
    input  logic             abort,
    output logic             rotary_a,
    output logic             rotary_b,
    output logic             busy,
    output logic             done
);

    localparam int PW = $clog2(PHASE_CYCLES) + 1;
    localparam logic [PW-1:0] PH_LAST = PW'(PHASE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PH1,
        S_PH2,
        S_PH3,
        S_GAP
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PW-1:0]    r_ph_cnt;
    logic [CNT_W-1:0] r_rem;
    logic [CNT_W-1:0] w_rem_nxt;
    logic             r_dir;
    logic             w_dir_nxt;
    logic             w_done_nxt;
    logic             w_a_nxt;
    logic             w_b_nxt;
    logic             w_ph_end;

    assign step_ready = (r_state == S_IDLE);
    assign w_ph_end   = (r_ph_cnt == PH_LAST);

    // Next-state logic: accept in IDLE, walk PH1..GAP per detent, abort only outside IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_dir_nxt   = r_dir;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (step_valid) begin
                    w_dir_nxt = step_dir;
                    w_rem_nxt = step_count;
                    // A zero-detent request completes immediately with no waveform.
                    if (step_count == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_PH1;
                    end
                end
            end
            default: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_rem_nxt   = '0;
                end else if (w_ph_end) begin
                    case (r_state)
                        S_PH1:   w_state_nxt = S_PH2;
                        S_PH2:   w_state_nxt = S_PH3;
                        S_PH3:   w_state_nxt = S_GAP;
                        default: begin
                            if (r_rem > CNT_W'(1)) begin
                                w_rem_nxt   = r_rem - CNT_W'(1);
                                w_state_nxt = S_PH1;
                            end else begin
                                w_rem_nxt   = '0;
                                w_state_nxt = S_IDLE;
                                w_done_nxt  = 1'b1;
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    // Output decode from the next state so the registered pins move on the same edge as the state.
    always_comb begin
        w_a_nxt = 1'b0;
        w_b_nxt = 1'b0;
        case (w_state_nxt)
            S_PH1: begin
                w_a_nxt = ~w_dir_nxt;
                w_b_nxt = w_dir_nxt;
            end
            S_PH2: begin
                w_a_nxt = 1'b1;
                w_b_nxt = 1'b1;
            end
            S_PH3: begin
                w_a_nxt = w_dir_nxt;
                w_b_nxt = ~w_dir_nxt;
            end
            default: begin
                w_a_nxt = 1'b0;
                w_b_nxt = 1'b0;
            end
        endcase
    end

    // State, phase timer, latched request and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ph_cnt <= '0;
            r_rem    <= '0;
            r_dir    <= 1'b0;
            rotary_a <= 1'b0;
            rotary_b <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            // Timer restarts on every state change and stays parked at 0 while idle.
            if ((w_state_nxt != r_state) || (r_state == S_IDLE)) begin
                r_ph_cnt <= '0;
            end else begin
                r_ph_cnt <= r_ph_cnt + PW'(1);
            end
            r_rem    <= w_rem_nxt;
            r_dir    <= w_dir_nxt;
            rotary_a <= w_a_nxt;
            rotary_b <= w_b_nxt;
            busy     <= (w_state_nxt != S_IDLE);
            done     <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_rotary_quad_gen.sv
// Directed bench for rotary_quad_gen: a PHASE_CYCLES=4 instance plus a PHASE_CYCLES=1 instance.
// Inputs are driven on the falling edge, outputs sampled on the falling edge after each rising edge.
// Waveforms are checked cycle by cycle against the hand-written A/B tables.
module tb_rotary_quad_gen;

    localparam int P = 4;

    logic       clk;
    logic       reset;
    logic       s_valid, s_dir, s_abort;
    logic [3:0] s_count;
    logic       s_ready, s_a, s_b, s_busy, s_done;
    logic       t_valid, t_dir, t_abort;
    logic [3:0] t_count;
    logic       t_ready, t_a, t_b, t_busy, t_done;

    int n_tests = 0;
    int n_fail  = 0;
    int lvl;

    rotary_quad_gen #(.PHASE_CYCLES(P), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .step_valid(s_valid), .step_ready(s_ready), .step_dir(s_dir),
        .step_count(s_count), .abort(s_abort),
        .rotary_a(s_a), .rotary_b(s_b), .busy(s_busy), .done(s_done)
    );

    rotary_quad_gen #(.PHASE_CYCLES(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset),
        .step_valid(t_valid), .step_ready(t_ready), .step_dir(t_dir),
        .step_count(t_count), .abort(t_abort),
        .rotary_a(t_a), .rotary_b(t_b), .busy(t_busy), .done(t_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Hand-written (a,b) table: phase 0..3 = PH1, PH2, PH3, GAP.
    function automatic logic [1:0] pat(input logic dir, input int idx);
        case (idx)
            0:       pat = dir ? 2'b01 : 2'b10;
            1:       pat = 2'b11;
            2:       pat = dir ? 2'b10 : 2'b01;
            default: pat = 2'b00;
        endcase
    endfunction

    // Caller has already raised s_valid; checks every cycle through the done cycle.
    task automatic expect_seq(input logic dir, input int ndet);
        logic [1:0] prev;
        logic [1:0] cur;
        int total;
        total = 16 * ndet;
        prev = {s_a, s_b};
        for (int k = 0; k <= total; k++) begin
            @(negedge clk);
            if (k == 0) begin
                s_valid = 1'b0;
                s_dir   = ~dir;
                s_count = 4'd7;
            end
            cur = {s_a, s_b};
            if (k < total) begin
                chk("ab", {30'd0, cur}, {30'd0, pat(dir, (k / P) % 4)});
                chk("busy", {31'd0, s_busy}, 32'd1);
                chk("done_low", {31'd0, s_done}, 32'd0);
                chk("ready_low", {31'd0, s_ready}, 32'd0);
            end else begin
                chk("ab_end", {30'd0, cur}, 32'd0);
                chk("busy_end", {31'd0, s_busy}, 32'd0);
                chk("done_pulse", {31'd0, s_done}, 32'd1);
                chk("ready_end", {31'd0, s_ready}, 32'd1);
            end
            chk("gray", {31'd0, ($countones(cur ^ prev) <= 1)}, 32'd1);
            if (prev == 2'b01 && cur == 2'b00) lvl = (lvl > 12) ? lvl - 1 : 12;
            if (prev == 2'b10 && cur == 2'b00) lvl = (lvl < 15) ? lvl + 1 : 15;
            prev = cur;
        end
    endtask

    initial begin
        logic [1:0] prev1;
        logic [1:0] cur1;
        reset = 1'b1;
        s_valid = 1'b0; s_dir = 1'b0; s_count = 4'd0; s_abort = 1'b0;
        t_valid = 1'b0; t_dir = 1'b0; t_count = 4'd0; t_abort = 1'b0;
        lvl = 14;
        #12;
        chk("rst_ab", {30'd0, s_a, s_b}, 32'd0);
        chk("rst_busy", {30'd0, s_busy, s_done}, 32'd0);
        chk("rst_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_ab1", {28'd0, t_a, t_b, t_busy, t_done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single increment detent.
        @(negedge clk);
        chk("idle_ready", {31'd0, s_ready}, 32'd1);
        s_valid = 1'b1; s_dir = 1'b1; s_count = 4'd1;
        expect_seq(1'b1, 1);

        // Decrement by three, accepted in the done cycle; paired decoder level clamps at 0xC.
        s_valid = 1'b1; s_dir = 1'b0; s_count = 4'd3;
        lvl = 14;
        expect_seq(1'b0, 3);
        chk("dec_level", lvl, 32'd12);

        // Back-to-back increments.
        s_valid = 1'b1; s_dir = 1'b1; s_count = 4'd2;
        expect_seq(1'b1, 2);
        s_valid = 1'b1; s_dir = 1'b1; s_count = 4'd1;
        expect_seq(1'b1, 1);

        // Zero-detent request.
        @(negedge clk);
        s_valid = 1'b1; s_count = 4'd0;
        @(negedge clk);
        s_valid = 1'b0;
        chk("z_done", {31'd0, s_done}, 32'd1);
        chk("z_busy_ab", {30'd0, s_busy, s_a | s_b}, 32'd0);
        chk("z_ready", {31'd0, s_ready}, 32'd1);
        @(negedge clk);
        chk("z_done_clr", {31'd0, s_done}, 32'd0);

        // Abort in PH2 of a 2-detent request.
        s_valid = 1'b1; s_dir = 1'b1; s_count = 4'd2;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k == 0) s_valid = 1'b0;
        end
        chk("ab_ph2", {30'd0, s_a, s_b}, 32'd3);
        s_abort = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_ab", {30'd0, s_a, s_b}, 32'd0);
            chk("abort_busy_done", {30'd0, s_busy, s_done}, 32'd0);
            chk("abort_ready", {31'd0, s_ready}, 32'd1);
        end
        // abort together with a request in IDLE: request wins.
        s_valid = 1'b1; s_dir = 1'b0; s_count = 4'd1;
        @(negedge clk);
        s_valid = 1'b0;
        s_abort = 1'b0;
        chk("av_ab", {30'd0, s_a, s_b}, 32'd2);
        chk("av_busy", {31'd0, s_busy}, 32'd1);
        s_abort = 1'b1;
        @(negedge clk);
        s_abort = 1'b0;
        chk("av_abort", {30'd0, s_a, s_b}, 32'd0);
        chk("av_nodone", {30'd0, s_busy, s_done}, 32'd0);

        // Asynchronous reset in PH3.
        @(negedge clk);
        s_valid = 1'b1; s_dir = 1'b1; s_count = 4'd1;
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            if (k == 0) s_valid = 1'b0;
        end
        chk("ab_ph3", {30'd0, s_a, s_b}, 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("arst_ab", {30'd0, s_a, s_b}, 32'd0);
        chk("arst_busy_done", {30'd0, s_busy, s_done}, 32'd0);
        chk("arst_ready", {31'd0, s_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        s_valid = 1'b1; s_dir = 1'b0; s_count = 4'd1;
        expect_seq(1'b0, 1);

        // PHASE_CYCLES=1 instance: two detents in 8 clocks, Gray on every edge.
        t_valid = 1'b1; t_dir = 1'b1; t_count = 4'd2;
        prev1 = {t_a, t_b};
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k == 0) t_valid = 1'b0;
            cur1 = {t_a, t_b};
            if (k < 8) begin
                chk("p1_ab", {30'd0, cur1}, {30'd0, pat(1'b1, k % 4)});
                chk("p1_busy_done", {30'd0, t_busy, t_done}, 32'd2);
            end else begin
                chk("p1_ab_end", {30'd0, cur1}, 32'd0);
                chk("p1_busy_done_end", {30'd0, t_busy, t_done}, 32'd1);
            end
            chk("p1_gray", {31'd0, ($countones(cur1 ^ prev1) <= 1)}, 32'd1);
            prev1 = cur1;
        end
        t_valid = 1'b1; t_count = 4'd0;
        @(negedge clk);
        t_valid = 1'b0;
        chk("p1_z_done", {30'd0, t_done, t_busy}, 32'd2);
        chk("p1_z_ab", {30'd0, t_a, t_b}, 32'd0);
        @(negedge clk);
        chk("p1_z_clr", {29'd0, t_done, t_a, t_b}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
